// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the sequenced ALU control unit.
//   - ALU control code values driven on alu_ctrl
//   - alu_op encodings produced by the main control unit
//   - FSM state and decoded-operation kind enumerations
package alu_ctrl_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_SLT     = 4'b0001;
    localparam logic [3:0] ALU_OR      = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_ADD     = 4'b0100;
    localparam logic [3:0] ALU_PASS    = 4'b0101;
    localparam logic [3:0] ALU_SLL1    = 4'b0110;
    localparam logic [3:0] ALU_SRA1    = 4'b0111;
    localparam logic [3:0] ALU_MULSTEP = 4'b1000;
    localparam logic [3:0] ALU_SUB     = 4'b1100;

    // alu_op encodings
    localparam logic [1:0] AOP_MEM   = 2'b00;
    localparam logic [1:0] AOP_BEQ   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ITYPE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_SINGLE = 2'd0,
        KIND_SHIFT  = 2'd1,
        KIND_MUL    = 2'd2
    } kind_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational instruction decoder.
// Maps (alu_op, opcode, funct) to an ALU code, an operation kind and an
// illegal flag. MUL (R-format opcode 0011, funct 00) decodes only when the
// ALU_MUL_EN macro is defined; otherwise it is illegal.
// Ports:
//   alu_op  in  2        operation class from the main control unit
//   opcode  in  OPC_W    instruction opcode
//   funct   in  FUNCT_W  R-format function field
//   code    out CTRL_W   ALU control code (single-step code for shifts)
//   kind    out kind_t   single, shift or mul
//   illegal out 1        encoding is not mapped
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int FUNCT_W = 2,
    parameter int CTRL_W  = 4
) (
    input  logic [1:0]         alu_op,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  code,
    output kind_t              kind,
    output logic               illegal
);

    // Decode table; every unmatched branch flags illegal.
    always_comb begin
        code    = CTRL_W'(ALU_AND);
        kind    = KIND_SINGLE;
        illegal = 1'b0;
        case (alu_op)
            AOP_MEM: begin
                code = CTRL_W'(ALU_ADD);
            end
            AOP_BEQ: begin
                code = CTRL_W'(ALU_SUB);
            end
            AOP_ITYPE: begin
                if (opcode == OPC_W'(4'b1001)) begin
                    code = CTRL_W'(ALU_ADD);
                end else if (opcode == OPC_W'(4'b1010)) begin
                    code = CTRL_W'(ALU_SUB);
                end else if (opcode == OPC_W'(4'b1011)) begin
                    code = CTRL_W'(ALU_SLT);
                end else begin
                    illegal = 1'b1;
                end
            end
            AOP_RTYPE: begin
                if (opcode == OPC_W'(4'b0000)) begin
                    if (funct == FUNCT_W'(2'b00)) begin
                        code = CTRL_W'(ALU_AND);
                    end else if (funct == FUNCT_W'(2'b01)) begin
                        code = CTRL_W'(ALU_OR);
                    end else if (funct == FUNCT_W'(2'b10)) begin
                        code = CTRL_W'(ALU_XOR);
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (opcode == OPC_W'(4'b0001)) begin
                    if (funct == FUNCT_W'(2'b00)) begin
                        code = CTRL_W'(ALU_ADD);
                    end else if (funct == FUNCT_W'(2'b01)) begin
                        code = CTRL_W'(ALU_SUB);
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (opcode == OPC_W'(4'b0010)) begin
                    kind = KIND_SHIFT;
                    if (funct == FUNCT_W'(2'b00)) begin
                        code = CTRL_W'(ALU_SLL1);
                    end else if (funct == FUNCT_W'(2'b01)) begin
                        code = CTRL_W'(ALU_SRA1);
                    end else begin
                        kind    = KIND_SINGLE;
                        illegal = 1'b1;
                    end
`ifdef ALU_MUL_EN
                end else if ((opcode == OPC_W'(4'b0011)) && (funct == FUNCT_W'(2'b00))) begin
                    code = CTRL_W'(ALU_MULSTEP);
                    kind = KIND_MUL;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control sequencer.
// Accepts one decoded instruction per in_valid/in_ready handshake and emits
// a stream of ALU control codes: one step for single-cycle ops, N single-bit
// steps for a shift by N (one PASS step for N = 0), DATA_W MULSTEP steps for
// MUL when the ALU_MUL_EN macro is defined.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   instruction handshake
//   alu_op, opcode, funct, shamt   instruction fields, sampled at accept
//   out_valid, alu_ctrl   step strobe and ALU control code
//   step_first/step_last  first / final step of the current op
//   illegal               one-cycle pulse for an unmapped encoding
//   busy                  multi-step sequence in progress (stall)
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int OPC_W   = 4,
    parameter int FUNCT_W = 2,
    parameter int CTRL_W  = 4,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               step_first,
    output logic               step_last,
    output logic               illegal,
    output logic               busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_t              state_r, state_n_s;
    logic [CNT_W-1:0]    cnt_r, cnt_n_s;
    logic [CTRL_W-1:0]   dec_code_s, first_code_s;
    kind_t               dec_kind_s;
    logic                dec_illegal_s;
    logic                accept_s;
    logic [CNT_W-1:0]    steps_s;

    logic                out_valid_r, out_valid_n_s;
    logic [CTRL_W-1:0]   alu_ctrl_r, alu_ctrl_n_s;
    logic                step_first_r, step_first_n_s;
    logic                step_last_r, step_last_n_s;
    logic                illegal_r, illegal_n_s;
    logic                busy_r, busy_n_s;

    alu_ctrl_decode #(
        .OPC_W   (OPC_W),
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_decode (
        .alu_op  (alu_op),
        .opcode  (opcode),
        .funct   (funct),
        .code    (dec_code_s),
        .kind    (dec_kind_s),
        .illegal (dec_illegal_s)
    );

    // Ready in IDLE or on the last step, so the next op issues without a bubble.
    assign in_ready = (state_r == ST_IDLE) || step_last_r;
    assign accept_s = in_valid && in_ready;

    // Step count and first code of the op being accepted; shift by 0 is one PASS.
    always_comb begin
        steps_s      = CNT_W'(1);
        first_code_s = dec_code_s;
        case (dec_kind_s)
            KIND_SHIFT: begin
                if (shamt == SHAMT_W'(0)) begin
                    first_code_s = CTRL_W'(ALU_PASS);
                end else begin
                    steps_s = CNT_W'(shamt);
                end
            end
            KIND_MUL: begin
                steps_s = CNT_W'(DATA_W);
            end
            KIND_SINGLE: begin
                steps_s = CNT_W'(1);
            end
            default: begin
                steps_s = CNT_W'(1);
            end
        endcase
    end

    // Next state, remaining-step count and next output values.
    // cnt_r counts the step currently on the outputs plus those still to come.
    always_comb begin
        state_n_s      = ST_IDLE;
        cnt_n_s        = '0;
        out_valid_n_s  = 1'b0;
        alu_ctrl_n_s   = alu_ctrl_r;
        step_first_n_s = 1'b0;
        step_last_n_s  = 1'b0;
        illegal_n_s    = 1'b0;
        busy_n_s       = 1'b0;
        if (accept_s) begin
            if (dec_illegal_s) begin
                illegal_n_s = 1'b1;
            end else begin
                out_valid_n_s  = 1'b1;
                alu_ctrl_n_s   = first_code_s;
                step_first_n_s = 1'b1;
                step_last_n_s  = (steps_s == CNT_W'(1));
                busy_n_s       = (steps_s > CNT_W'(1));
                cnt_n_s        = steps_s;
                state_n_s      = (steps_s > CNT_W'(1)) ? ST_REPEAT : ST_ISSUE;
            end
        end else if ((state_r == ST_REPEAT) && (cnt_r > CNT_W'(1))) begin
            state_n_s     = ST_REPEAT;
            cnt_n_s       = cnt_r - CNT_W'(1);
            out_valid_n_s = 1'b1;
            step_last_n_s = (cnt_r == CNT_W'(2));
            busy_n_s      = (cnt_r > CNT_W'(2));
        end else begin
            state_n_s = ST_IDLE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            out_valid_r  <= 1'b0;
            alu_ctrl_r   <= '0;
            step_first_r <= 1'b0;
            step_last_r  <= 1'b0;
            illegal_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
            out_valid_r  <= out_valid_n_s;
            alu_ctrl_r   <= alu_ctrl_n_s;
            step_first_r <= step_first_n_s;
            step_last_r  <= step_last_n_s;
            illegal_r    <= illegal_n_s;
            busy_r       <= busy_n_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign alu_ctrl   = alu_ctrl_r;
    assign step_first = step_first_r;
    assign step_last  = step_last_r;
    assign illegal    = illegal_r;
    assign busy       = busy_r;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised successor to the combinational ALU control decoder of the 16-bit CPU. Accepts one decoded instruction per handshake (ALUOp, opcode, funct, shift amount) and emits a stream of ALU control codes. Single-cycle ops produce one code. Shifts by N are sequenced as N single-bit ALU steps, and an optional iterative multiply is sequenced the same way. It sits between the main control unit and the ALU, and drives the pipeline stall through `busy`.

## Interface
- `DATA_W`, 16: datapath width; sets the maximum shift amount and the multiply step count.
- `OPC_W`, 4: opcode width.
- `FUNCT_W`, 2: funct width.
- `CTRL_W`, 4: ALU control code width.
- `SHAMT_W`, $clog2(DATA_W): shift-amount width.

Ports:
- `clk` in 1: the single clock; every register updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: instruction presented.
- `in_ready` out 1: instruction can be accepted this cycle.
- `alu_op` in 2: 00 = LW/SW, 01 = BEQ, 10 = R-format, 11 = I-format.
- `opcode` in OPC_W: instruction opcode.
- `funct` in FUNCT_W: R-format function field.
- `shamt` in SHAMT_W: shift amount; only used by SLL and SRA.
- `out_valid` out 1: `alu_ctrl` is a valid step this cycle.
- `alu_ctrl` out CTRL_W: ALU control code.
- `step_first` out 1: first step of the current op.
- `step_last` out 1: final step of the current op.
- `illegal` out 1: one-cycle pulse for an unmapped encoding.
- `busy` out 1: a multi-step sequence is in progress; the control unit stalls while it is high.

## Operation
- Codes: AND 0000, SLT 0001, OR 0010, XOR 0011, ADD 0100, PASS 0101, SLL1 0110, SRA1 0111, MULSTEP 1000, SUB 1100.
- Decode for `alu_op`:
  - 00: ADD.
  - 01: SUB.
  - 11 (I-format): opcode 1001 ADD, 1010 SUB, 1011 SLT.
  - 10 (R-format): opcode 0000 with funct 00/01/10 gives AND/OR/XOR. Opcode 0001 with funct 00/01 gives ADD/SUB. Opcode 0010 with funct 00/01 gives SLL/SRA.
  - 10 (R-format), opcode 0011 with funct 00: MUL (only when `ALU_MUL_EN` is defined).
- Any other combination is illegal.
- An instruction is accepted when `in_valid && in_ready`. Input fields are sampled only at accept.
- FSM states:
  - IDLE to ISSUE: single-step op accepted.
  - IDLE to REPEAT: shift with shamt ≥ 2, or MUL.
  - ISSUE to IDLE, or to ISSUE/REPEAT if a new accept happens in the same cycle.
  - REPEAT to REPEAT while remaining count > 1.
  - REPEAT to IDLE, or to a new op, on the last step.
- Shift by N ≥ 1: N consecutive steps of SLL1 or SRA1. Shift with shamt 0: one PASS step.
- MUL: DATA_W consecutive MULSTEP steps.
- The remaining-step counter is $clog2(DATA_W)+1 bits. It loads the step count at accept and decrements on each output step.
- Illegal encoding: accepted, then `illegal` pulses for one cycle. `out_valid` stays 0 and `alu_ctrl` holds its previous value. The FSM returns to IDLE.
- `in_ready` = (state == IDLE) or (`step_last` is asserted this cycle), which allows back-to-back issue with no bubble.
- `busy` = state == REPEAT and the remaining count is > 1.
- Downstream applies no backpressure; every `out_valid` cycle is consumed.

## Timing
- Reset values:
  - `out_valid`, `step_first`, `step_last`, `illegal`, `busy`: 0.
  - `alu_ctrl`: 0000.
  - FSM state: IDLE, so `in_ready` is 1.
- Latency: the first step appears on the cycle after accept. An op of N steps occupies N consecutive cycles.
- Single step: `out_valid`, `step_first` and `step_last` are all 1 in the same cycle.
- Throughput: one single-step op per cycle when `in_valid` is held.
- Reset asserted mid-sequence: the sequence aborts at the next edge with no further steps, and all outputs take their reset values.
- `in_valid` while not ready: ignored. The source holds its fields until accepted.

## Configuration
- `ALU_MUL_EN`, defined: MUL decodes and issues DATA_W MULSTEP steps.
- `ALU_MUL_EN`, undefined: opcode 0011 with funct 00 is illegal, and the MULSTEP code is never driven.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the ALU control code localparams;
  - the `alu_op` encodings;
  - the FSM state enum (IDLE, ISSUE, REPEAT).
- Sub-module `alu_ctrl_decode` is purely combinational. It maps (`alu_op`, `opcode`, `funct`) to a code, a kind (single, shift, mul) and an illegal flag.
- The top level holds only the FSM, the counter and the output registers.

## Test plan
- Reset, then accept `alu_op`=10, opcode 0000, funct 10: the next cycle has `out_valid`=1, `alu_ctrl`=0011, first=last=1, `busy`=0.
- Back-to-back accepts of ADDI (11/1001), then SUBI (11/1010): consecutive cycles give 0100 then 1100, and `in_ready` stays 1 throughout.
- SLL with shamt 5: five cycles of 0110, `step_first` on cycle 1 and `step_last` on cycle 5, `busy` high for the first 4 steps, `in_ready` high only on step 5.
- SRA with shamt 0: a single PASS step 0101. Opcode 0010 with funct 11: `illegal` pulses one cycle and `out_valid` stays 0.
- `ALU_MUL_EN` defined, MUL accepted: 16 cycles of 1000. Undefined: `illegal` pulses instead.
- SLL with shamt 15: `rst_n` driven low after 3 steps gives all outputs 0 and `in_ready`=1 at the next edge, with no further steps.
